// File: rtl/gate_exerciser.sv
// Sweeps a two-input gate through 00,01,10,11, checks its synchronized output against a
// selected truth table. Optional mismatch counter: define GATE_EXERCISER_ERRCNT_EN.
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] func,
  input  logic       c_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [7:0] err_cnt
);

  // Two synchronizer stages need at least three cycles per vector to settle.
  localparam int unsigned Settle = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(Settle + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            r_state, w_state_nxt;
  logic [1:0]        r_sync;
  logic [2:0]        r_func, w_func_nxt;
  logic [1:0]        r_k, w_k_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;
  logic              r_pass, w_pass_nxt;
  logic [3:0]        r_fail_vec, w_fail_nxt;
  logic              w_last;
  logic              w_expect;
  logic              w_mismatch;

  always_comb begin
    w_expect = 1'b0;
    unique case (r_func)
      3'd0: w_expect = r_k[1] & r_k[0];
      3'd1: w_expect = r_k[1] | r_k[0];
      3'd2: w_expect = r_k[1] ^ r_k[0];
      3'd3: w_expect = ~(r_k[1] & r_k[0]);
      3'd4: w_expect = ~(r_k[1] | r_k[0]);
      3'd5: w_expect = ~(r_k[1] ^ r_k[0]);
      3'd6: w_expect = 1'b0;
      3'd7: w_expect = 1'b1;
      default: w_expect = 1'b0;
    endcase
  end

  assign w_last     = (r_cnt == CntW'(Settle - 1));
  assign w_mismatch = (r_state == StRun) && w_last && (r_sync[1] != w_expect);

  always_comb begin
    w_state_nxt = r_state;
    w_func_nxt  = r_func;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_fail_nxt  = r_fail_vec;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StRun;
          w_func_nxt  = func;
          w_k_nxt     = 2'd0;
          w_cnt_nxt   = '0;
          w_pass_nxt  = 1'b0;
          w_fail_nxt  = 4'b0000;
        end
      end
      StRun: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_mismatch) w_fail_nxt[r_k] = 1'b1;
          if (r_k == 2'd3) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_fail_nxt == 4'b0000);
          end else begin
            w_k_nxt = r_k + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= 2'b00;
      r_func     <= 3'd0;
      r_k        <= 2'd0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_vec <= 4'b0000;
    end else begin
      r_sync     <= {r_sync[0], c_in};
      r_func     <= w_func_nxt;
      r_k        <= w_k_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_fail_vec <= w_fail_nxt;
    end
  end

`ifdef GATE_EXERCISER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'h00;
    end else if (w_mismatch && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

  assign busy     = (r_state == StRun);
  assign a_out    = busy & r_k[1];
  assign b_out    = busy & r_k[0];
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: S=4 instance for sweeps/reset/back-to-back, and an
// S=1 instance (clamped to 3) with a glitch on c_in in each vector's first cycle.
module tb_gate_exerciser;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] func;
  logic       c_in;
  logic       a_out, b_out, busy, done, pass;
  logic [3:0] fail_vec;
  logic [7:0] err_cnt;
  logic [1:0] c_mode;

  logic       start1;
  logic [2:0] func1;
  logic       c_in1;
  logic       glitch;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] fail_vec1;
  logic [7:0] err_cnt1;

  int n_cmp;
  int n_err;
  int exp_err;

  gate_exerciser #(.SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .c_in(c_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .fail_vec(fail_vec), .err_cnt(err_cnt)
  );

  gate_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .func(func1), .c_in(c_in1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fail_vec1), .err_cnt(err_cnt1)
  );

  // Gate-under-test models: 0 AND, 1 XOR, 2 tied high.
  always_comb begin
    c_in = 1'b0;
    case (c_mode)
      2'd0: c_in = a_out & b_out;
      2'd1: c_in = a_out ^ b_out;
      default: c_in = 1'b1;
    endcase
  end

  assign c_in1 = (a1 & b1) ^ glitch;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] err_exp();
`ifdef GATE_EXERCISER_ERRCNT_EN
    return 8'(exp_err);
`else
    return 8'h00;
`endif
  endfunction

  // Full S=4 sweep from the start cycle to the done cycle; func is disturbed mid-run.
  task automatic sweep(input logic [2:0] f, input logic [3:0] exp_fail, input bit hold);
    func  = f;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    func = f ^ 3'b111;
    for (int c = 1; c <= 16; c++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("ab_run", 32'({a_out, b_out}), 32'((c - 1) / 4));
      check("done_run", 32'(done), 32'd0);
      tick();
    end
    exp_err = exp_err + $countones(exp_fail);
    if (exp_err > 255) exp_err = 255;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("ab_idle", 32'({a_out, b_out}), 32'd0);
    check("fail_vec", 32'(fail_vec), 32'(exp_fail));
    check("pass", 32'(pass), 32'(exp_fail == 4'b0000));
    check("err_cnt", 32'(err_cnt), 32'(err_exp()));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_err = 0;
    rst     = 1'b1;
    start   = 1'b0;
    func    = 3'd0;
    c_mode  = 2'd0;
    start1  = 1'b0;
    func1   = 3'd0;
    glitch  = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail_vec), 32'd0);
    check("rst_ab", 32'({a_out, b_out}), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // AND gate, AND expected
    c_mode = 2'd0;
    sweep(3'd0, 4'b0000, 1'b0);
    // OR expected, AND gate: vectors 01 and 10 mismatch
    sweep(3'd1, 4'b0110, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_done", 32'(done), 32'd0);
      check("hold_fail", 32'(fail_vec), 32'b0110);
      check("hold_pass", 32'(pass), 32'd0);
    end

    // start held high: back-to-back sweeps with XOR
    c_mode = 2'd1;
    sweep(3'd2, 4'b0000, 1'b1);
    sweep(3'd2, 4'b0000, 1'b1);
    sweep(3'd2, 4'b0000, 1'b1);
    start = 1'b0;
    tick();
    check("b2b_idle", 32'(busy), 32'd0);

    // reset at cycle 9 of a sweep
    c_mode = 2'd0;
    func   = 3'd0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    check("pre_rst_ab", 32'({a_out, b_out}), 32'd2);
    rst = 1'b1;
    #1;
    exp_err = 0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ab", 32'({a_out, b_out}), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("no_done_after_rst", 32'(done), 32'd0);
      check("idle_after_rst", 32'(busy), 32'd0);
    end
    sweep(3'd0, 4'b0000, 1'b0);

    // tied-high gate: const1 passes, const0 fails everywhere
    c_mode = 2'd2;
    sweep(3'd7, 4'b0000, 1'b0);
    sweep(3'd6, 4'b1111, 1'b0);
    for (int i = 0; i < 63; i++) begin
      tick();
      sweep(3'd6, 4'b1111, 1'b0);
    end
    check("err_sat", 32'(err_cnt), 32'(err_exp()));

    // S=1 clamped to 3: done 13 cycles after start, first-cycle glitches not sampled
    tick();
    func1  = 3'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if ((c % 3) == 1) begin
        glitch = 1'b1;
        #3;
        glitch = 1'b0;
      end
      check("s1_busy", 32'(busy1), 32'd1);
      check("s1_ab", 32'({a1, b1}), 32'((c - 1) / 3));
      check("s1_done_run", 32'(done1), 32'd0);
      tick();
    end
    check("s1_done", 32'(done1), 32'd1);
    check("s1_busy_done", 32'(busy1), 32'd0);
    check("s1_pass", 32'(pass1), 32'd1);
    check("s1_fail", 32'(fail_vec1), 32'd0);
    check("s1_err", 32'(err_cnt1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
